// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requester with a one-entry skid buffer.
// Optional macro FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] pc_address,
  output logic        valid,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_addr_q, pc_addr_d;
  logic        valid_q, valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        halt_q, halt_d;

  logic [31:0] redirect_pc;
  logic        misalign_hit;
  logic        handshake;
  logic        capture;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_pc  = redirect_target;
  assign misalign_hit = |redirect_target[1:0];
  assign misalign_err = halt_q;
`else
  assign redirect_pc  = redirect_target & 32'hFFFF_FFFC;
  assign misalign_hit = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Requests pause while the skid buffer holds a word so at most two words are ever in the stage.
  assign imem_req_valid = (state_q == S_REQ) && !buf_valid_q;
  assign imem_addr      = pc_q;
  assign instruction    = instr_q;
  assign pc_address     = pc_addr_q;
  assign valid          = valid_q;

  assign handshake = imem_req_valid && imem_req_ready;
  assign capture   = (state_q == S_WAIT) && imem_rsp_valid && !redirect;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_addr_d   = pc_addr_q;
    valid_d     = valid_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    halt_d      = halt_q;

    if (!halt_q) begin
      if (redirect) begin
        valid_d     = 1'b0;
        buf_valid_d = 1'b0;
        pc_d        = redirect_pc;
        unique case (state_q)
          S_IDLE:  state_d = S_REQ;
          S_REQ:   state_d = handshake ? S_DROP : S_REQ;
          S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
          S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
          default: state_d = S_IDLE;
        endcase
        if (misalign_hit) begin
          halt_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        if (capture) begin
          pc_d = pc_q + 32'd4;
          if (!valid_q || !stall) begin
            instr_d   = imem_rsp_data;
            pc_addr_d = pc_q;
            valid_d   = 1'b1;
          end else begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rsp_data;
            buf_pc_d    = pc_q;
          end
        end else if (valid_q && !stall) begin
          if (buf_valid_q) begin
            instr_d     = buf_instr_q;
            pc_addr_d   = buf_pc_q;
            buf_valid_d = 1'b0;
          end else begin
            valid_d = 1'b0;
          end
        end
        unique case (state_q)
          S_IDLE:  state_d = S_REQ;
          S_REQ:   state_d = handshake ? S_WAIT : S_REQ;
          S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_WAIT;
          S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= NOP;
      pc_addr_q   <= 32'h0000_0000;
      valid_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP;
      buf_pc_q    <= 32'h0000_0000;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_addr_q   <= pc_addr_d;
      valid_q     <= valid_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      halt_q      <= halt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic against an in-order fetch-stream model
// with a behavioural single-outstanding memory.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MASK     = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic [31:0] pc_address;
  logic        valid;
  logic        misalign_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_txn    = 0;

  // Memory model and expected fetch stream
  logic        pending   = 1'b0;
  int          wait_cnt  = 0;
  logic [31:0] pend_addr = '0;
  int          rsp_delay = 1;
  logic [31:0] exp_pc    = RESET_PC;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instruction     (instruction),
    .pc_address      (pc_address),
    .valid           (valid),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, sample DUT before the edge, check after it, advance the models.
  task automatic step(input logic s_rst, input logic s_stall, input logic s_redir,
                      input logic [31:0] s_tgt, input logic s_ready);
    logic        p_req, p_valid, hs, rsp_now;
    logic [31:0] p_addr, p_instr, p_pc;
    rst             = s_rst;
    stall           = s_stall;
    redirect        = s_redir;
    redirect_target = s_tgt;
    imem_req_ready  = s_ready;
    rsp_now         = pending && (wait_cnt == 0);
    imem_rsp_valid  = rsp_now;
    imem_rsp_data   = rsp_now ? mem_word(pend_addr) : $urandom();
    @(negedge clk);
    p_req   = imem_req_valid;
    p_addr  = imem_addr;
    p_valid = valid;
    p_instr = instruction;
    p_pc    = pc_address;
    hs      = p_req && s_ready;
    @(posedge clk);
    #1;
    if (!s_rst && p_valid && !s_stall && !s_redir) begin
      chk("stream_pc", p_pc, exp_pc);
      chk("stream_instr", p_instr, mem_word(exp_pc));
      $display("txn %0d: pc=%08h instr=%08h", n_txn, p_pc, p_instr);
      n_txn++;
      exp_pc = exp_pc + 32'd4;
    end
    if (!s_rst && p_valid && s_stall && !s_redir) begin
      chk("stall_hold_valid", {31'b0, valid}, 32'd1);
      chk("stall_hold_pc", pc_address, p_pc);
      chk("stall_hold_instr", instruction, p_instr);
    end
    if (!s_rst && s_redir)
      chk("redirect_flush_valid", {31'b0, valid}, 32'd0);
    if (!s_rst && p_req && !s_ready && !s_redir) begin
      chk("req_held", {31'b0, imem_req_valid}, 32'd1);
      chk("addr_stable", imem_addr, p_addr);
    end
    if (hs)
      chk("one_outstanding", {31'b0, pending}, 32'd0);
    if (rsp_now) pending = 1'b0;
    else if (pending) wait_cnt--;
    if (hs) begin
      pending   = 1'b1;
      wait_cnt  = rsp_delay - 1;
      pend_addr = p_addr;
    end
    if (s_rst) exp_pc = RESET_PC;
    else if (s_redir) exp_pc = s_tgt & MASK;
  endtask

  task automatic run(input logic s_stall, input logic s_ready);
    step(1'b0, s_stall, 1'b0, 32'h0, s_ready);
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_pc_address", pc_address, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // Reset release and zero-wait fetch sequence
    run(0, 1);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_addr, RESET_PC);
    run(0, 1);
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    run(0, 1);
    chk("first_valid", {31'b0, valid}, 32'd1);
    chk("first_pc_address", pc_address, 32'd0);
    chk("first_instr", instruction, mem_word(32'd0));
    chk("second_addr", imem_addr, 32'd4);
    run(0, 1);
    run(0, 1);
    chk("third_addr", imem_addr, 32'd8);

    // Stall 4 cycles: second word lands in skid buffer, requests stop
    repeat (4) run(1, 1);
    chk("stall_pc_address", pc_address, 32'd4);
    chk("stall_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    run(0, 1);
    chk("unstall_valid", {31'b0, valid}, 32'd1);
    chk("unstall_buffer_word", pc_address, 32'd8);
    chk("unstall_next_addr", imem_addr, 32'd12);

    // Redirect while waiting on a slow response
    rsp_delay = 2;
    run(0, 1);
    rsp_delay = 1;
    step(0, 0, 1, 32'h100, 1);
    chk("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
    run(0, 1);
    chk("drop_discard_valid", {31'b0, valid}, 32'd0);
    chk("redirect_addr", imem_addr, 32'h100);
    run(0, 1);
    run(0, 1);
    chk("redirect_word_valid", {31'b0, valid}, 32'd1);
    chk("redirect_word_pc", pc_address, 32'h100);

    // Redirect coincident with response while stalled
    run(1, 1);
    step(0, 1, 1, 32'h200, 1);
    chk("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h200);

    // PC wrap at top of address space
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
    run(0, 1);
    run(0, 1);
    chk("wrap_pc_address", pc_address, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_addr, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rsp_delay = $urandom_range(1, 3);
      t = $urandom();
      if (t[4]) t = 32'hFFFF_FFF0 | {28'b0, t[3:0]};
      step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0), t & MASK,
           ($urandom_range(0, 3) != 0));
    end
    chk("random_progress", {31'b0, (n_txn > 60)}, 32'd1);

    // Reset during an outstanding request; the late response must be ignored
    repeat (5) run(0, 0);
    chk("settle_req_valid", {31'b0, imem_req_valid}, 32'd1);
    rsp_delay = 3;
    run(0, 1);
    step(1, 0, 0, 32'h0, 0);
    run(0, 0);
    run(0, 0);
    chk("stale_rsp_ignored", {31'b0, valid}, 32'd0);
    chk("post_reset_addr", imem_addr, RESET_PC);
    rsp_delay = 1;
    run(0, 1);
    run(0, 1);
    chk("post_reset_pc", pc_address, RESET_PC);

    // Misaligned redirect target
    step(0, 0, 1, 32'h102, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_set", {31'b0, misalign_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      run(0, 1);
      chk("misalign_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    chk("misalign_sticky", {31'b0, misalign_err}, 32'd1);
`else
    chk("misalign_tied0", {31'b0, misalign_err}, 32'd0);
    chk("misalign_forced_addr", imem_addr, 32'h100);
    run(0, 1);
    run(0, 1);
    chk("misalign_fetch_pc", pc_address, 32'h100);
`endif
    run(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
